// File: rtl/tekno_flash_pkg.sv
// Shared definitions for the iomem SPI flash reader.
//   FLASH_CMD_READ : opcode of the plain (slow) READ command
//   FRAME_LEN      : bits per SPI frame (8 cmd + 24 addr + 32 data)
//   BIT_CNT_W      : width of the in-frame bit counter (0..63)
//   state_t        : responder FSM states
//   le_word()      : reorders bytes received MSB-first into a little-endian word
package tekno_flash_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int         FRAME_LEN      = 64;
  localparam int         BIT_CNT_W      = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WACK,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } state_t;

  // The shift register holds {b0,b1,b2,b3} with the first byte received on
  // top; the bus wants the first byte at the lowest address.
  function automatic logic [31:0] le_word(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: half-period timing, 64-bit shift-out, shift-in, SCK.
//   clk_i, rst_ni : system clock, asynchronous active-low reset
//   load_i        : capture tx_i (frame accepted this cycle)
//   tx_i          : 64-bit outgoing frame, MSB sent first
//   active_i      : frame in progress (setup, shift or hold phase)
//   shift_i       : bit-shifting phase
//   miso_i        : serial data from the flash
//   tick_o        : last cycle of the current half-period
//   done_o        : last cycle of the final bit's high phase
//   sck_o, mosi_o : SPI clock and data to the flash
//   rx_o          : last 32 bits received, first bit in rx_o[31]
module spi_bit_engine
  import tekno_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [FRAME_LEN-1:0] tx_i,
  input  logic                 active_i,
  input  logic                 shift_i,
  input  logic                 miso_i,
  output logic                 tick_o,
  output logic                 done_o,
  output logic                 sck_o,
  output logic                 mosi_o,
  output logic [31:0]          rx_o
);

  localparam int HP_W = $clog2(CLK_DIV + 1);

  logic [HP_W-1:0]      hp_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 sck_q;
  logic [FRAME_LEN-1:0] tx_q;
  logic [31:0]          rx_q;
  logic                 last_bit;

  assign tick_o   = active_i && (hp_cnt_q == HP_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt_q == BIT_CNT_W'(FRAME_LEN - 1));
  assign done_o   = shift_i && tick_o && sck_q && last_bit;
  assign sck_o    = sck_q;
  // Shifting happens as SCK falls, so MOSI changes on entry to each low phase.
  assign mosi_o   = tx_q[FRAME_LEN-1];
  assign rx_o     = rx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hp_cnt_q  <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      tx_q      <= '0;
    end else if (load_i) begin
      hp_cnt_q  <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      tx_q      <= tx_i;
    end else if (!active_i) begin
      hp_cnt_q <= '0;
      sck_q    <= 1'b0;
    end else begin
      hp_cnt_q <= tick_o ? '0 : hp_cnt_q + 1'b1;
      if (shift_i && tick_o) begin
        sck_q <= ~sck_q;
        if (sck_q) begin
          tx_q <= {tx_q[FRAME_LEN-2:0], 1'b0};
          if (!last_bit) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Sample once per bit, in the first cycle SCK is high. Only the final 32
  // samples survive in the register, which are exactly the data bits.
  always_ff @(posedge clk_i) begin
    if (shift_i && sck_q && (hp_cnt_q == '0)) begin
      rx_q <= {rx_q[30:0], miso_i};
    end
  end

endmodule

// File: rtl/iomem_flash_reader.sv
// iomem-bus responder serving 32-bit reads from an SPI NOR flash (READ 0x03).
//   clk_i, rst_ni  : system clock, asynchronous active-low reset
//   iomem_valid_i  : request valid, held until ready
//   iomem_wstrb_i  : byte write strobes, zero for a read
//   iomem_addr_i   : byte address; window decode on the upper bits
//   iomem_ready_o  : one-cycle completion pulse for in-window requests
//   iomem_rdata_o  : read data, held until the next read completion
//   spi_cs_o       : flash chip select, active low
//   spi_sck_o      : SPI clock, mode 0
//   spi_mosi_o     : to flash SI
//   spi_miso_i     : from flash SO
// Writes are acknowledged without touching the flash.
module iomem_flash_reader
  import tekno_flash_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] FLASH_MASK_ADDR = 32'h00ff_ffff,
  parameter int          CLK_DIV         = 2,
  parameter int          CS_GAP_CYCLES   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iomem_valid_i,
  input  logic [3:0]  iomem_wstrb_i,
  input  logic [31:0] iomem_addr_i,
  output logic        iomem_ready_o,
  output logic [31:0] iomem_rdata_o,
  output logic        spi_cs_o,
  output logic        spi_sck_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int GAP_W = $clog2(CS_GAP_CYCLES + 1);

  state_t               state_q, state_d;
  logic                 keep_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [31:0]          rdata_q;

  logic                 sel;
  logic                 load;
  logic                 frame_active;
  logic                 tick;
  logic                 done;
  logic [31:0]          spi_rx;
  logic [FRAME_LEN-1:0] tx_frame;

  assign sel  = iomem_valid_i && ((iomem_addr_i & ~FLASH_MASK_ADDR) == FLASH_BASE_ADDR);
  assign load = (state_q == ST_IDLE) && sel && (iomem_wstrb_i == 4'b0000);

  assign tx_frame     = {FLASH_CMD_READ, iomem_addr_i[23:2], 2'b00, 32'h0};
  assign frame_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  // CS follows the state register so an asynchronous reset releases it at once.
  assign spi_cs_o      = ~frame_active;
  assign iomem_ready_o = (state_q == ST_WACK) || ((state_q == ST_DONE) && keep_q);
  assign iomem_rdata_o = rdata_q;

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (load),
    .tx_i     (tx_frame),
    .active_i (frame_active),
    .shift_i  (state_q == ST_SHIFT),
    .miso_i   (spi_miso_i),
    .tick_o   (tick),
    .done_o   (done),
    .sck_o    (spi_sck_o),
    .mosi_o   (spi_mosi_o),
    .rx_o     (spi_rx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sel) state_d = (iomem_wstrb_i != 4'b0000) ? ST_WACK : ST_SETUP;
      ST_WACK:  state_d = ST_IDLE;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (done) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_DONE;
      // DONE already counts as the first CS-high cycle of the gap.
      ST_DONE:  state_d = (CS_GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt_q == GAP_W'(CS_GAP_CYCLES - 2)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      keep_q    <= 1'b0;
      gap_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      // A master that lets valid drop mid-frame has abandoned the read; the
      // frame still runs to completion but its data is discarded.
      if (load) begin
        keep_q <= 1'b1;
      end else if (frame_active) begin
        keep_q <= keep_q & iomem_valid_i;
      end
      if ((state_q == ST_HOLD) && tick && keep_q && iomem_valid_i) begin
        rdata_q <= le_word(spi_rx);
      end
      if (state_q == ST_DONE) begin
        gap_cnt_q <= '0;
      end else if (state_q == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q + 1'b1;
      end
    end
  end

endmodule
